pipe_hazard_ctrl: RTL and testbench

//  Hazard and forwarding controller for the 5-stage core (IF/ID/EX/MEM/WB).

---
 rtl/pipe_hazard_ctrl.sv | 160 ++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/forwarding controller for a 5-stage pipeline. It keeps shadow copies of the
// EX/MEM/WB destinations and decodes stall, flush, forward and bypass selects from them.
module pipe_hazard_ctrl #(
    parameter int REG_AW   = 5,
    parameter int FWD_EN   = 1,
    parameter int BR_STAGE = 3,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_write,
    input  logic              id_is_load,
    input  logic              redirect,
    output logic              stall_front,
    output logic              bubble_idex,
    output logic              flush_ifid,
    output logic              flush_idex,
    output logic              flush_exmem,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              id_byp_rs1,
    output logic              id_byp_rs2,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              we;
        logic              is_load;
    } stg_t;

    localparam logic [REG_AW-1:0] ZERO_REG = {REG_AW{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    stg_t              ex_r, mem_r, wb_r;
    logic [REG_AW-1:0] ex_rs1_r, ex_rs2_r;
    logic              ex_use1_r, ex_use2_r;
    logic [CNT_W-1:0]  stall_cnt_r, flush_cnt_r;

    logic raw_ex_s, raw_mem_s, raw_wb_s, stall_s;
    logic stall_front_s, flush_exmem_s;
    logic [1:0] fwd_a_s, fwd_b_s;

    // x0 is hard-wired to zero, so it never creates a dependency.
    function automatic logic match_f(input stg_t s, input logic [REG_AW-1:0] r);
        return s.valid & s.we & (s.rd != ZERO_REG) & (s.rd == r);
    endfunction

    function automatic logic raw_f(input stg_t s, input logic v,
                                   input logic u1, input logic [REG_AW-1:0] r1,
                                   input logic u2, input logic [REG_AW-1:0] r2);
        return v & ((u1 & match_f(s, r1)) | (u2 & match_f(s, r2)));
    endfunction

    // The younger producer (MEM) holds the newer value, so it wins over WB.
    function automatic logic [1:0] fwd_f(input logic en, input logic [REG_AW-1:0] rs,
                                         input stg_t m, input stg_t w);
        logic [1:0] sel;
        sel = 2'b00;
        if (en) begin
            if (match_f(m, rs)) begin
                sel = 2'b01;
            end else if (match_f(w, rs)) begin
                sel = 2'b10;
            end else begin
                sel = 2'b00;
            end
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    // Hazard detection and select decode from shadows plus the ID instruction.
    always_comb begin
        raw_ex_s  = raw_f(ex_r,  id_valid, id_use_rs1, id_rs1, id_use_rs2, id_rs2);
        raw_mem_s = raw_f(mem_r, id_valid, id_use_rs1, id_rs1, id_use_rs2, id_rs2);
        raw_wb_s  = raw_f(wb_r,  id_valid, id_use_rs1, id_rs1, id_use_rs2, id_rs2);
        if (FWD_EN != 0) begin
            stall_s = raw_ex_s & ex_r.is_load;
        end else begin
            stall_s = raw_ex_s | raw_mem_s | raw_wb_s;
        end
        stall_front_s = stall_s & ~redirect;
        if (BR_STAGE == 3) begin
            flush_exmem_s = redirect;
        end else begin
            flush_exmem_s = 1'b0;
        end
        fwd_a_s = fwd_f((FWD_EN != 0) & ex_r.valid & ex_use1_r, ex_rs1_r, mem_r, wb_r);
        fwd_b_s = fwd_f((FWD_EN != 0) & ex_r.valid & ex_use2_r, ex_rs2_r, mem_r, wb_r);
    end

    // Shadow pipeline advance and saturating performance counters.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ex_r        <= '{valid: 1'b0, rd: ZERO_REG, we: 1'b0, is_load: 1'b0};
            mem_r       <= '{valid: 1'b0, rd: ZERO_REG, we: 1'b0, is_load: 1'b0};
            wb_r        <= '{valid: 1'b0, rd: ZERO_REG, we: 1'b0, is_load: 1'b0};
            ex_rs1_r    <= ZERO_REG;
            ex_rs2_r    <= ZERO_REG;
            ex_use1_r   <= 1'b0;
            ex_use2_r   <= 1'b0;
            stall_cnt_r <= {CNT_W{1'b0}};
            flush_cnt_r <= {CNT_W{1'b0}};
        end else begin
            wb_r <= mem_r;
            if (flush_exmem_s) begin
                mem_r <= '{valid: 1'b0, rd: ZERO_REG, we: 1'b0, is_load: 1'b0};
            end else begin
                mem_r <= ex_r;
            end
            if (stall_s || redirect) begin
                ex_r      <= '{valid: 1'b0, rd: ZERO_REG, we: 1'b0, is_load: 1'b0};
                ex_rs1_r  <= ZERO_REG;
                ex_rs2_r  <= ZERO_REG;
                ex_use1_r <= 1'b0;
                ex_use2_r <= 1'b0;
            end else begin
                ex_r      <= '{valid: id_valid, rd: id_rd, we: id_reg_write, is_load: id_is_load};
                ex_rs1_r  <= id_rs1;
                ex_rs2_r  <= id_rs2;
                ex_use1_r <= id_use_rs1;
                ex_use2_r <= id_use_rs2;
            end
            if (stall_front_s && (stall_cnt_r != CNT_MAX)) begin
                stall_cnt_r <= stall_cnt_r + CNT_ONE;
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            if (redirect && (flush_cnt_r != CNT_MAX)) begin
                flush_cnt_r <= flush_cnt_r + CNT_ONE;
            end else begin
                flush_cnt_r <= flush_cnt_r;
            end
        end
    end

    assign stall_front = stall_front_s;
    assign bubble_idex = stall_front_s;
    assign flush_ifid  = redirect;
    assign flush_idex  = redirect;
    assign flush_exmem = flush_exmem_s;
    assign fwd_a       = fwd_a_s;
    assign fwd_b       = fwd_b_s;
    assign id_byp_rs1  = id_use_rs1 & match_f(wb_r, id_rs1);
    assign id_byp_rs2  = id_use_rs2 & match_f(wb_r, id_rs2);
    assign stall_cnt   = stall_cnt_r;
    assign flush_cnt   = flush_cnt_r;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: a forwarding/MEM-resolve instance and a non-forwarding/EX-resolve
// instance with 4-bit counters share one stimulus stream; an instruction-flow model scores both.
module tb_pipe_hazard_ctrl;

    typedef struct packed {
        logic       v;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       we;
        logic       ld;
    } ins_t;

    typedef struct packed {
        logic        sf, bub, fi, fe, fm;
        logic [1:0]  fa, fb;
        logic        b1, b2;
        logic [15:0] sc, fc;
    } out_t;

    logic clk = 1'b0;
    logic rst, id_valid, id_use_rs1, id_use_rs2, id_reg_write, id_is_load, redirect;
    logic [4:0] id_rs1, id_rs2, id_rd;

    logic a_sf, a_bub, a_fi, a_fe, a_fm, a_b1, a_b2;
    logic [1:0] a_fa, a_fb;
    logic [15:0] a_sc, a_fc;
    logic b_sf, b_bub, b_fi, b_fe, b_fm, b_b1, b_b2;
    logic [1:0] b_fa, b_fb;
    logic [3:0] b_sc, b_fc;

    int n_vec = 0;
    int n_err = 0;

    ins_t cur;
    ins_t m_ex[2], m_mem[2], m_wb[2];
    int   m_sc[2], m_fc[2];
    out_t sb_q[$];

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.REG_AW(5), .FWD_EN(1), .BR_STAGE(3), .CNT_W(16)) u_fwd (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_is_load(id_is_load), .redirect(redirect),
        .stall_front(a_sf), .bubble_idex(a_bub), .flush_ifid(a_fi), .flush_idex(a_fe),
        .flush_exmem(a_fm), .fwd_a(a_fa), .fwd_b(a_fb), .id_byp_rs1(a_b1), .id_byp_rs2(a_b2),
        .stall_cnt(a_sc), .flush_cnt(a_fc));

    pipe_hazard_ctrl #(.REG_AW(5), .FWD_EN(0), .BR_STAGE(2), .CNT_W(4)) u_nofwd (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_is_load(id_is_load), .redirect(redirect),
        .stall_front(b_sf), .bubble_idex(b_bub), .flush_ifid(b_fi), .flush_idex(b_fe),
        .flush_exmem(b_fm), .fwd_a(b_fa), .fwd_b(b_fb), .id_byp_rs1(b_b1), .id_byp_rs2(b_b2),
        .stall_cnt(b_sc), .flush_cnt(b_fc));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic ins_t nop();
        return '{v: 1'b0, rs1: 5'd0, rs2: 5'd0, u1: 1'b0, u2: 1'b0, rd: 5'd0, we: 1'b0, ld: 1'b0};
    endfunction

    function automatic ins_t alu(input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2);
        return '{v: 1'b1, rs1: s1, rs2: s2, u1: 1'b1, u2: 1'b1, rd: d, we: 1'b1, ld: 1'b0};
    endfunction

    function automatic ins_t lw(input logic [4:0] d, input logic [4:0] s1);
        return '{v: 1'b1, rs1: s1, rs2: 5'd0, u1: 1'b1, u2: 1'b0, rd: d, we: 1'b1, ld: 1'b1};
    endfunction

    function automatic logic writes(input ins_t p, input logic [4:0] r);
        return p.v && p.we && (p.rd != 5'd0) && (p.rd == r);
    endfunction

    function automatic logic depends(input ins_t p);
        return cur.v && ((cur.u1 && writes(p, cur.rs1)) || (cur.u2 && writes(p, cur.rs2)));
    endfunction

    function automatic logic [1:0] src(input logic fen, input ins_t c, input logic u,
                                       input logic [4:0] r, input ins_t m, input ins_t w);
        if (!fen || !c.v || !u) return 2'd0;
        if (writes(m, r)) return 2'd1;
        if (writes(w, r)) return 2'd2;
        return 2'd0;
    endfunction

    function automatic out_t model_out(input int c, input logic fen, input int br);
        out_t o;
        logic hz;
        if (fen) hz = depends(m_ex[c]) && m_ex[c].ld;
        else     hz = depends(m_ex[c]) || depends(m_mem[c]) || depends(m_wb[c]);
        o.sf  = hz && !redirect;
        o.bub = o.sf;
        o.fi  = redirect;
        o.fe  = redirect;
        o.fm  = redirect && (br == 3);
        o.fa  = src(fen, m_ex[c], m_ex[c].u1, m_ex[c].rs1, m_mem[c], m_wb[c]);
        o.fb  = src(fen, m_ex[c], m_ex[c].u2, m_ex[c].rs2, m_mem[c], m_wb[c]);
        o.b1  = cur.u1 && writes(m_wb[c], cur.rs1);
        o.b2  = cur.u2 && writes(m_wb[c], cur.rs2);
        o.sc  = 16'(m_sc[c]);
        o.fc  = 16'(m_fc[c]);
        return o;
    endfunction

    task automatic advance(input int c, input out_t e, input int cmax);
        if (!rst) begin
            m_ex[c] = nop(); m_mem[c] = nop(); m_wb[c] = nop();
            m_sc[c] = 0; m_fc[c] = 0;
        end else begin
            m_wb[c]  = m_mem[c];
            m_mem[c] = e.fm ? nop() : m_ex[c];
            m_ex[c]  = (e.sf || redirect) ? nop() : cur;
            if (e.sf && m_sc[c] < cmax) m_sc[c]++;
            if (redirect && m_fc[c] < cmax) m_fc[c]++;
        end
    endtask

    task automatic chk_out(input string p, input out_t o, input out_t e);
        check({p, "stall_front"}, o.sf, e.sf);
        check({p, "bubble_idex"}, o.bub, e.bub);
        check({p, "flush_ifid"}, o.fi, e.fi);
        check({p, "flush_idex"}, o.fe, e.fe);
        check({p, "flush_exmem"}, o.fm, e.fm);
        check({p, "fwd_a"}, o.fa, e.fa);
        check({p, "fwd_b"}, o.fb, e.fb);
        check({p, "id_byp_rs1"}, o.b1, e.b1);
        check({p, "id_byp_rs2"}, o.b2, e.b2);
        check({p, "stall_cnt"}, o.sc, e.sc);
        check({p, "flush_cnt"}, o.fc, e.fc);
    endtask

    // One clock: drive ID at negedge, score both instances, then advance the model.
    task automatic step(input ins_t i, input logic redir, input logic rst_v);
        out_t ea, eb, oa, ob;
        @(negedge clk);
        cur = i; redirect = redir; rst = rst_v;
        id_valid = i.v; id_rs1 = i.rs1; id_rs2 = i.rs2; id_use_rs1 = i.u1; id_use_rs2 = i.u2;
        id_rd = i.rd; id_reg_write = i.we; id_is_load = i.ld;
        sb_q.push_back(model_out(0, 1'b1, 3));
        sb_q.push_back(model_out(1, 1'b0, 2));
        #1;
        oa = '{a_sf, a_bub, a_fi, a_fe, a_fm, a_fa, a_fb, a_b1, a_b2, a_sc, a_fc};
        ob = '{b_sf, b_bub, b_fi, b_fe, b_fm, b_fa, b_fb, b_b1, b_b2, {12'd0, b_sc}, {12'd0, b_fc}};
        ea = sb_q.pop_front();
        eb = sb_q.pop_front();
        chk_out("fwd.", oa, ea);
        chk_out("nofwd.", ob, eb);
        advance(0, ea, 65535);
        advance(1, eb, 15);
    endtask

    task automatic do_reset();
        step(nop(), 1'b0, 1'b0);
        step(nop(), 1'b0, 1'b0);
    endtask

    initial begin
        for (int c = 0; c < 2; c++) begin
            m_ex[c] = nop(); m_mem[c] = nop(); m_wb[c] = nop(); m_sc[c] = 0; m_fc[c] = 0;
        end
        cur = nop(); rst = 1'b0; redirect = 1'b0;
        id_valid = 1'b0; id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        id_rd = 5'd0; id_reg_write = 1'b0; id_is_load = 1'b0;
        do_reset();
        step(nop(), 1'b0, 1'b1);
        check("rst_stall_cnt", a_sc, 32'd0);
        check("rst_fwd_a", a_fa, 32'd0);

        // ALU producer forwarded from EX/MEM.
        do_reset();
        step(alu(5'd5, 5'd1, 5'd2), 1'b0, 1'b1);
        step(alu(5'd8, 5'd5, 5'd3), 1'b0, 1'b1);
        check("t1_no_stall", a_sf, 32'd0);
        step(nop(), 1'b0, 1'b1);
        check("t1_fwd_a", a_fa, 32'd1);

        // Load-use: one stall, then forward from MEM/WB.
        do_reset();
        step(lw(5'd6, 5'd1), 1'b0, 1'b1);
        step(alu(5'd7, 5'd6, 5'd6), 1'b0, 1'b1);
        check("t2_stall", a_sf, 32'd1);
        step(alu(5'd7, 5'd6, 5'd6), 1'b0, 1'b1);
        check("t2_release", a_sf, 32'd0);
        step(nop(), 1'b0, 1'b1);
        check("t2_fwd_a", a_fa, 32'd2);
        check("t2_fwd_b", a_fb, 32'd2);
        check("t2_stall_cnt", a_sc, 32'd1);

        // No forwarding: consumer held in ID until producer leaves WB.
        do_reset();
        step(alu(5'd5, 5'd1, 5'd2), 1'b0, 1'b1);
        step(alu(5'd8, 5'd5, 5'd3), 1'b0, 1'b1);
        check("t3_stall1", b_sf, 32'd1);
        step(alu(5'd8, 5'd5, 5'd3), 1'b0, 1'b1);
        check("t3_stall2", b_sf, 32'd1);
        step(alu(5'd8, 5'd5, 5'd3), 1'b0, 1'b1);
        check("t3_stall3", b_sf, 32'd1);
        check("t3_byp", b_b1, 32'd1);
        step(alu(5'd8, 5'd5, 5'd3), 1'b0, 1'b1);
        check("t3_release", b_sf, 32'd0);
        check("t3_fwd_a", b_fa, 32'd0);

        // Redirect overrides a pending load-use stall.
        do_reset();
        step(lw(5'd6, 5'd1), 1'b0, 1'b1);
        step(alu(5'd7, 5'd6, 5'd6), 1'b1, 1'b1);
        check("t4_stall", a_sf, 32'd0);
        check("t4_flush_ifid", a_fi, 32'd1);
        check("t4_flush_idex", a_fe, 32'd1);
        check("t4_flush_exmem", a_fm, 32'd1);
        check("t4_exmem_br2", b_fm, 32'd0);
        step(nop(), 1'b0, 1'b1);
        check("t4_flush_cnt", a_fc, 32'd1);

        // Writes to x0 never create hazards.
        do_reset();
        step(alu(5'd0, 5'd1, 5'd2), 1'b0, 1'b1);
        step(lw(5'd0, 5'd1), 1'b0, 1'b1);
        step(alu(5'd0, 5'd3, 5'd4), 1'b0, 1'b1);
        step(alu(5'd9, 5'd0, 5'd0), 1'b0, 1'b1);
        check("t5_stall_fwd", a_sf, 32'd0);
        check("t5_stall_nofwd", b_sf, 32'd0);
        check("t5_byp", b_b1, 32'd0);
        step(nop(), 1'b0, 1'b1);
        check("t5_fwd_a", a_fa, 32'd0);

        // Random traffic on a small register window.
        for (int n = 0; n < 400; n++) begin
            ins_t r;
            r.v = ($urandom_range(0, 7) != 0); r.rs1 = 5'($urandom_range(0, 3));
            r.rs2 = 5'($urandom_range(0, 3)); r.u1 = 1'($urandom_range(0, 1));
            r.u2 = 1'($urandom_range(0, 1)); r.rd = 5'($urandom_range(0, 3));
            r.we = 1'($urandom_range(0, 1)); r.ld = 1'($urandom_range(0, 1));
            step(r, ($urandom_range(0, 7) == 0), ($urandom_range(0, 63) != 0));
        end

        // Saturate the 4-bit stall counter, then reset.
        do_reset();
        for (int k = 0; k < 7; k++) begin
            step(alu(5'd5, 5'd1, 5'd2), 1'b0, 1'b1);
            for (int j = 0; j < 3; j++) step(alu(5'd6, 5'd5, 5'd5), 1'b0, 1'b1);
        end
        step(nop(), 1'b0, 1'b1);
        check("t6_sat", b_sc, 32'd15);
        step(nop(), 1'b0, 1'b0);
        step(nop(), 1'b0, 1'b1);
        check("t6_cnt_clr", b_sc, 32'd0);
        check("t6_sf_clr", b_sf, 32'd0);

        // Reset in the middle of a stall.
        step(alu(5'd5, 5'd1, 5'd2), 1'b0, 1'b1);
        step(alu(5'd6, 5'd5, 5'd5), 1'b0, 1'b1);
        step(alu(5'd6, 5'd5, 5'd5), 1'b0, 1'b0);
        step(alu(5'd6, 5'd5, 5'd5), 1'b0, 1'b1);
        check("t6_mid_rst_stall", b_sf, 32'd0);
        check("t6_mid_rst_flush", b_fi, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
